// File: rtl/spi_mem_bridge_pkg.sv
// Shared definitions for the SPI memory bridge: command byte layout,
// FSM state encoding and an elaboration-time ceil(log2) helper.
package spi_mem_bridge_pkg;

    localparam int unsigned CMD_WR_BIT   = 7;
    localparam int unsigned CMD_INC_BIT  = 6;
    localparam int unsigned CMD_RSVD_MSB = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        DISCARD
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if (value > (32'd1 << i)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_mem_ram.sv
// Single-port synchronous RAM, 1-clk read latency, contents not reset.
// Ports: clk; en (access strobe); we (1=write, 0=read); addr; din; dout (registered).
module spi_mem_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            else    dout      <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave to on-chip RAM bridge. SPI pins are oversampled on clk;
// a frame is cmd byte, address bytes (MSB first), then data words (MSB first),
// single-word or auto-incrementing burst, for both writes and prefetched reads.
// Ports: clk, reset (async, active-high); ss/sclk/mosi (async SPI inputs);
// miso/miso_oe (SPI out + drive enable); busy (frame active);
// frame_done (1-clk pulse at ss rise); cmd_err (sticky reserved-bit error).
module spi_mem_bridge
    import spi_mem_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ss,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic busy,
    output logic frame_done,
    output logic cmd_err
);

    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int unsigned ACC_W      = ADDR_BYTES * 8;
    localparam int unsigned MAX_BYTES  = (DATA_BYTES > ADDR_BYTES) ? DATA_BYTES : ADDR_BYTES;
    localparam int unsigned BCNT_W     = clog2(MAX_BYTES) + 1;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   ss_d, sclk_d;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall_c, ss_rise_c, sclk_rise_c, sclk_fall_c;

    state_t                 state, state_n;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [7:0]             rx_byte_c;
    logic [BCNT_W-1:0]      byte_cnt;
    logic                   byte_done_c, last_addr_c, last_data_c, rsvd_err_c;
    logic                   cmd_wr, cmd_inc;
    logic [ACC_W-1:0]       addr_acc, addr_acc_n_c;
    logic [ADDR_WIDTH-1:0]  addr, addr_new_c, addr_inc_c;
    logic [DATA_WIDTH-1:0]  wdata_acc, wdata_word_c, tx_shift;
    logic                   rd_load, tx_skip;

    logic                   ram_en, ram_we;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0]  ram_din, ram_dout;

    // Synchroniser outputs and edge detection on the last two samples
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign ss_fall_c   = ss_d & ~ss_s;
    assign ss_rise_c   = ~ss_d & ss_s;
    assign sclk_rise_c = ~sclk_d & sclk_s;
    assign sclk_fall_c = sclk_d & ~sclk_s;

    // Byte assembly and phase decoding; an ss rise suppresses the coincident sclk edge
    assign rx_byte_c    = {rx_shift, mosi_s};
    assign byte_done_c  = sclk_rise_c && !ss_rise_c && (state != IDLE) && (bit_cnt == 3'd7);
    assign last_addr_c  = (byte_cnt == BCNT_W'(ADDR_BYTES - 1));
    assign last_data_c  = (byte_cnt == BCNT_W'(DATA_BYTES - 1));
    assign rsvd_err_c   = |rx_byte_c[CMD_RSVD_MSB:0];
    assign addr_acc_n_c = ACC_W'({addr_acc, rx_byte_c});
    assign addr_new_c   = ADDR_WIDTH'(addr_acc_n_c);
    assign addr_inc_c   = addr + ADDR_WIDTH'(1);
    assign wdata_word_c = DATA_WIDTH'({wdata_acc, rx_byte_c});

    // miso comes straight from the MSB of the transmit shift flop
    assign miso = tx_shift[DATA_WIDTH-1];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // FSM next-state logic
    always_comb begin
        state_n = state;
        if (ss_rise_c) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall_c) state_n = CMD;
                CMD:     if (byte_done_c) state_n = rsvd_err_c ? DISCARD : ADDR;
                ADDR:    if (byte_done_c && last_addr_c) state_n = cmd_wr ? WDATA : RDATA;
                WDATA:   if (byte_done_c && last_data_c && !cmd_inc) state_n = DISCARD;
                RDATA:   if (byte_done_c && last_data_c && !cmd_inc) state_n = DISCARD;
                DISCARD: state_n = DISCARD;
                default: state_n = IDLE;
            endcase
        end
    end

    // Synchronisers, receive path, address/data capture and RAM requests
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_sync    <= '1;
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            ss_d       <= 1'b1;
            sclk_d     <= 1'b0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            byte_cnt   <= '0;
            cmd_wr     <= 1'b0;
            cmd_inc    <= 1'b0;
            addr_acc   <= '0;
            addr       <= '0;
            wdata_acc  <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            rd_load    <= 1'b0;
        end else begin
            ss_sync    <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_d       <= ss_s;
            sclk_d     <= sclk_s;
            miso_oe    <= ~ss_s;
            busy       <= (state_n != IDLE);
            frame_done <= ss_rise_c && (state != IDLE);
            ram_en     <= 1'b0;
            rd_load    <= ram_en & ~ram_we;

            if (ss_fall_c && (state == IDLE)) begin
                cmd_err  <= 1'b0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                addr_acc <= '0;
            end else if (sclk_rise_c && !ss_rise_c && (state != IDLE)) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte_c[6:0];
                if (byte_done_c) begin
                    case (state)
                        CMD: begin
                            cmd_wr  <= rx_byte_c[CMD_WR_BIT];
                            cmd_inc <= rx_byte_c[CMD_INC_BIT];
                            if (rsvd_err_c) cmd_err <= 1'b1;
                        end
                        ADDR: begin
                            addr_acc <= addr_acc_n_c;
                            if (last_addr_c) begin
                                addr     <= addr_new_c;
                                byte_cnt <= '0;
                                if (!cmd_wr) begin
                                    ram_en   <= 1'b1;
                                    ram_we   <= 1'b0;
                                    ram_addr <= addr_new_c;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + BCNT_W'(1);
                            end
                        end
                        WDATA: begin
                            wdata_acc <= wdata_word_c;
                            if (last_data_c) begin
                                // commit the word next clk; addr moves on for the burst
                                ram_en   <= 1'b1;
                                ram_we   <= 1'b1;
                                ram_addr <= addr;
                                ram_din  <= wdata_word_c;
                                addr     <= addr_inc_c;
                                byte_cnt <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + BCNT_W'(1);
                            end
                        end
                        RDATA: begin
                            if (last_data_c) begin
                                byte_cnt <= '0;
                                if (cmd_inc) begin
                                    ram_en   <= 1'b1;
                                    ram_we   <= 1'b0;
                                    ram_addr <= addr_inc_c;
                                    addr     <= addr_inc_c;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + BCNT_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Transmit shifter. A freshly loaded word always lands just before the
    // trailing fall of the previous byte, so that one fall must not shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift <= '0;
            tx_skip  <= 1'b0;
        end else if (state_n != RDATA) begin
            tx_shift <= '0;
            tx_skip  <= 1'b0;
        end else if (rd_load) begin
            tx_shift <= ram_dout;
            tx_skip  <= 1'b1;
        end else if (sclk_fall_c) begin
            if (tx_skip) tx_skip  <= 1'b0;
            else         tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    spi_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: table of SPI frames with hand-computed
// miso data and cmd_err, plus sequences for abort, cmd_err clear and reset.
module tb_spi_mem_bridge;

    localparam int HALF = 50;   // sclk half period in ns; clk period is 10 ns

    logic clk = 1'b0;
    logic reset, ss, sclk, mosi;
    logic miso, miso_oe, busy, frame_done, cmd_err;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    spi_mem_bridge #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ss         (ss),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .busy       (busy),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_count++;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        int          nbytes;
        logic [63:0] wdata;
        logic [63:0] exp_rx;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #(HALF);
            sclk = 1'b1;
            rx[i] = miso;
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_open();
        fd_count = 0;
        @(negedge clk);
        #2;
        ss = 1'b0;
        #(4 * HALF);
    endtask

    task automatic frame_close();
        #(2 * HALF);
        ss = 1'b1;
        #(8 * HALF);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                             input logic [63:0] data, output logic [63:0] rx);
        logic [7:0]  b;
        logic [63:0] d;
        d  = data;
        rx = '0;
        frame_open();
        spi_byte(cmd, b);
        spi_byte(addr, b);
        for (int i = 0; i < n; i++) begin
            spi_byte(d[63:56], b);
            rx[63 - 8 * i -: 8] = b;
            d = d << 8;
        end
        frame_close();
    endtask

    initial begin
        logic [63:0] rx;
        logic [7:0]  b;

        vecs[0]  = '{8'h80, 8'h03, 4, 64'hDEADBEEF_00000000, 64'h0, 1'b0};
        vecs[1]  = '{8'h00, 8'h03, 4, 64'h0, 64'hDEADBEEF_00000000, 1'b0};
        vecs[2]  = '{8'hC0, 8'h0F, 8, 64'h11223344_55667788, 64'h0, 1'b0};
        vecs[3]  = '{8'h40, 8'h0F, 8, 64'h0, 64'h11223344_55667788, 1'b0};
        vecs[4]  = '{8'h80, 8'h02, 8, 64'hA1A2A3A4_A5A6A7A8, 64'h0, 1'b0};
        vecs[5]  = '{8'h00, 8'h02, 4, 64'h0, 64'hA1A2A3A4_00000000, 1'b0};
        vecs[6]  = '{8'h00, 8'h03, 8, 64'h0, 64'hDEADBEEF_00000000, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 4, 64'h0, 64'h55667788_00000000, 1'b0};
        vecs[8]  = '{8'h80, 8'h04, 4, 64'hCAFEF00D_00000000, 64'h0, 1'b0};
        vecs[9]  = '{8'h80, 8'h05, 4, 64'h12345678_00000000, 64'h0, 1'b0};
        vecs[10] = '{8'h80, 8'h06, 4, 64'h66666666_00000000, 64'h0, 1'b0};
        vecs[11] = '{8'h81, 8'h04, 4, 64'h01020304_00000000, 64'h0, 1'b1};
        vecs[12] = '{8'h00, 8'h04, 4, 64'h0, 64'hCAFEF00D_00000000, 1'b0};

        reset = 1'b1;
        ss    = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {miso, miso_oe, busy, frame_done, cmd_err}, 5'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_outputs", {miso, miso_oe, busy, frame_done, cmd_err}, 5'b0);

        for (int v = 0; v < 13; v++) begin
            run_frame(vecs[v].cmd, vecs[v].addr, vecs[v].nbytes, vecs[v].wdata, rx);
            check($sformatf("vec%0d_miso", v), rx, vecs[v].exp_rx);
            check($sformatf("vec%0d_cmd_err", v), cmd_err, vecs[v].exp_err);
            check($sformatf("vec%0d_frame_done", v), fd_count, 1);
            check($sformatf("vec%0d_busy", v), busy, 1'b0);
        end

        // Aborted write: partial word must not reach memory
        frame_open();
        spi_byte(8'h80, b);
        check("abort_busy_mid", {busy, miso_oe}, 2'b11);
        spi_byte(8'h05, b);
        spi_byte(8'hAA, b);
        spi_byte(8'hBB, b);
        frame_close();
        check("abort_frame_done_width", fd_count, 1);
        check("abort_idle", busy, 1'b0);
        run_frame(8'h00, 8'h05, 4, 64'h0, rx);
        check("abort_mem5", rx, 64'h12345678_00000000);

        // cmd_err set, then cleared at the next ss fall
        run_frame(8'h81, 8'h04, 4, 64'h01020304_00000000, rx);
        check("rsvd_err_set", cmd_err, 1'b1);
        frame_open();
        check("rsvd_err_clear", cmd_err, 1'b0);
        spi_byte(8'h00, b);
        spi_byte(8'h04, b);
        rx = '0;
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, b);
            rx[63 - 8 * i -: 8] = b;
        end
        frame_close();
        check("rsvd_mem4", rx, 64'hCAFEF00D_00000000);

        // Reset mid-WDATA after two data bytes
        frame_open();
        spi_byte(8'h80, b);
        spi_byte(8'h06, b);
        spi_byte(8'h11, b);
        spi_byte(8'h22, b);
        @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("midframe_reset_outputs", {miso, miso_oe, busy, frame_done, cmd_err}, 5'b0);
        ss = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        run_frame(8'h00, 8'h06, 4, 64'h0, rx);
        check("post_reset_mem6_kept", rx, 64'h66666666_00000000);
        run_frame(8'h80, 8'h06, 4, 64'h0BADCAFE_00000000, rx);
        check("post_reset_write_frame_done", fd_count, 1);
        run_frame(8'h00, 8'h06, 4, 64'h0, rx);
        check("post_reset_mem6_new", rx, 64'h0BADCAFE_00000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
